// File: rtl/gnrl_fifo.sv
// gnrl_fifo: flop-based valid/ready FIFO with occupancy count and flush.
// Depth need not be a power of two; pointers wrap by explicit compare.
module gnrl_fifo #(
    parameter int DW = 32,
    parameter int DP = 4,
    localparam int CW = $clog2(DP + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DP > 1) ? $clog2(DP) : 1;
    localparam logic [PW-1:0] LAST = PW'(DP - 1);

    logic [DW-1:0] mem_q [DP];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    assign full  = (count_q == CW'(DP));
    assign empty = (count_q == '0);
    assign i_rdy = ~full;
    assign o_vld = ~empty;
    assign o_dat = mem_q[rptr_q];
    assign count = count_q;

    // Handshakes, pointer wrap and occupancy; flush overrides both sides.
    always_comb begin
        push    = i_vld & i_rdy;
        pop     = o_vld & o_rdy;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = (wptr_q == LAST) ? '0 : wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = (rptr_q == LAST) ? '0 : rptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage: written on an accepted push; a flush keeps old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DP; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !flush) begin
            mem_q[wptr_q] <= i_dat;
        end
    end

endmodule

// File: tb/tb_gnrl_fifo.sv
// tb_gnrl_fifo: queue-model scoreboard for a DP=4 and a DP=3 FIFO.
// Directed scenarios plus randomized valid/ready traffic.
module tb_gnrl_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, i_vld, o_rdy;
    logic [31:0] i_dat;
    logic        i_rdy, o_vld, full, empty;
    logic [31:0] o_dat;
    logic [2:0]  count;

    logic        flush3, i_vld3, o_rdy3;
    logic [7:0]  i_dat3;
    logic        i_rdy3, o_vld3, full3, empty3;
    logic [7:0]  o_dat3;
    logic [1:0]  count3;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] q4[$];
    logic [7:0]  q3[$];
    int rcv3 = 0;

    always #5 clk = ~clk;

    gnrl_fifo #(.DW(32), .DP(4)) u4 (
        .clk(clk), .rst(rst), .flush(flush),
        .i_vld(i_vld), .i_rdy(i_rdy), .i_dat(i_dat),
        .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat),
        .count(count), .full(full), .empty(empty)
    );

    gnrl_fifo #(.DW(8), .DP(3)) u3 (
        .clk(clk), .rst(rst), .flush(flush3),
        .i_vld(i_vld3), .i_rdy(i_rdy3), .i_dat(i_dat3),
        .o_vld(o_vld3), .o_rdy(o_rdy3), .o_dat(o_dat3),
        .count(count3), .full(full3), .empty(empty3)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic flags4();
        int n;
        n = q4.size();
        chk("cnt4", 64'(count), 64'(n));
        chk("ovld4", 64'(o_vld), 64'(n != 0));
        chk("irdy4", 64'(i_rdy), 64'(n != 4));
        chk("full4", 64'(full), 64'(n == 4));
        chk("empty4", 64'(empty), 64'(n == 0));
    endtask

    // one clock of the DP=4 FIFO with the current inputs; acc = push taken
    task automatic step4(output bit acc);
        bit pop, fl;
        logic [31:0] d;
        #1;
        if (q4.size() > 0) chk("head4", 64'(o_dat), 64'(q4[0]));
        fl  = flush;
        acc = i_vld && (q4.size() < 4) && !fl;
        pop = o_rdy && (q4.size() > 0);
        d   = i_dat;
        @(posedge clk);
        if (fl) begin
            q4.delete();
        end else begin
            if (pop) void'(q4.pop_front());
            if (acc) q4.push_back(d);
        end
        #1;
        flags4();
    endtask

    task automatic step3();
        bit acc, pop;
        logic [7:0] d;
        #1;
        if (q3.size() > 0) chk("head3", 64'(o_dat3), 64'(q3[0]));
        acc = i_vld3 && (q3.size() < 3);
        pop = o_rdy3 && (q3.size() > 0);
        d   = i_dat3;
        @(posedge clk);
        if (pop) begin
            void'(q3.pop_front());
            rcv3++;
        end
        if (acc) q3.push_back(d);
        #1;
        chk("cnt3", 64'(count3), 64'(q3.size()));
        chk("c3max", 64'(count3 <= 2'd3), 64'd1);
        chk("ovld3", 64'(o_vld3), 64'(q3.size() != 0));
        chk("full3", 64'(full3), 64'(q3.size() == 3));
    endtask

    initial begin
        bit acc;
        int val, cyc;
        logic [7:0] nxt;
        rst = 1'b1; flush = 1'b0; i_vld = 1'b0; o_rdy = 1'b0; i_dat = '0;
        flush3 = 1'b0; i_vld3 = 1'b0; o_rdy3 = 1'b0; i_dat3 = '0;
        #12;
        flags4();
        chk("rst_odat", 64'(o_dat), 64'd0);
        chk("rst_cnt3", 64'(count3), 64'd0);
        rst = 1'b0;

        // two entries queued, then asynchronous reset mid-cycle
        i_vld = 1'b1;
        i_dat = 32'h11; step4(acc);
        i_dat = 32'h22; step4(acc);
        i_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        q4.delete();
        flags4();
        chk("arst_odat", 64'(o_dat), 64'd0);
        #1 rst = 1'b0;
        i_vld = 1'b1; i_dat = 32'hA5A5_0001;
        step4(acc);
        i_vld = 1'b0;
        chk("rst_push_vld", 64'(o_vld), 64'd1);
        chk("rst_push_dat", 64'(o_dat), 64'hA5A5_0001);
        o_rdy = 1'b1; step4(acc); o_rdy = 1'b0;

        // fill with 1..5 while stalled, then drain
        val = 1;
        i_vld = 1'b1;
        for (int k = 0; k < 6; k++) begin
            i_dat = 32'(val);
            step4(acc);
            if (acc) val++;
        end
        chk("held_off", 64'(val), 64'd5);
        chk("fill_full", 64'(full), 64'd1);
        o_rdy = 1'b1;
        cyc = 0;
        while ((val <= 5 || q4.size() > 0) && cyc < 20) begin
            i_vld = (val <= 5);
            i_dat = 32'(val);
            step4(acc);
            if (acc) val++;
            cyc++;
        end
        chk("drain_done", 64'(cyc < 20), 64'd1);
        chk("drain_empty", 64'(empty), 64'd1);

        // steady push+pop at count 2
        o_rdy = 1'b0; i_vld = 1'b1;
        i_dat = 32'h100; step4(acc);
        i_dat = 32'h101; step4(acc);
        o_rdy = 1'b1;
        for (int j = 0; j < 10; j++) begin
            i_dat = 32'h102 + 32'(j);
            #1 chk("pp_dly", 64'(o_dat), 64'(32'h100 + 32'(j)));
            step4(acc);
            chk("pp_cnt", 64'(count), 64'd2);
        end

        // flush at count 3 with push and pop requested
        o_rdy = 1'b0; i_dat = 32'h300; step4(acc);
        chk("fl_pre", 64'(count), 64'd3);
        flush = 1'b1; o_rdy = 1'b1; i_dat = 32'h777;
        step4(acc);
        flush = 1'b0; o_rdy = 1'b0;
        chk("fl_cnt", 64'(count), 64'd0);
        chk("fl_empty", 64'(empty), 64'd1);
        i_dat = 32'hDEAD_BEEF; step4(acc);
        i_vld = 1'b0;
        chk("fl_first", 64'(o_dat), 64'hDEAD_BEEF);

        // ignored requests: pop while empty, push while full
        o_rdy = 1'b1;
        for (int k = 0; k < 6; k++) step4(acc);
        chk("ign_empty", 64'(count), 64'd0);
        o_rdy = 1'b0; i_vld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_dat = 32'h400 + 32'(k); step4(acc);
        end
        for (int k = 0; k < 5; k++) begin
            i_dat = 32'hBAD0 + 32'(k); step4(acc);
            chk("ign_full", 64'(o_dat), 64'h400);
        end
        i_vld = 1'b1; i_dat = 32'h500; o_rdy = 1'b1;
        for (int k = 0; k < 4; k++) step4(acc);
        i_vld = 1'b0;
        for (int k = 0; k < 4; k++) step4(acc);
        o_rdy = 1'b0;
        chk("ign_after", 64'(empty), 64'd1);

        // random traffic on DP=4
        for (int k = 0; k < 300; k++) begin
            i_vld = 1'($urandom);
            o_rdy = 1'($urandom);
            flush = ($urandom_range(0, 31) == 0);
            i_dat = $urandom;
            step4(acc);
        end
        flush = 1'b0; i_vld = 1'b0; o_rdy = 1'b0;

        // DP=3 stream 0x00..0x1F with random handshakes
        nxt = 8'h00;
        cyc = 0;
        while (rcv3 < 32 && cyc < 600) begin
            i_vld3 = (nxt < 8'h20) && ($urandom_range(0, 3) != 0);
            o_rdy3 = ($urandom_range(0, 2) != 0);
            i_dat3 = nxt;
            if (i_vld3 && q3.size() < 3) nxt++;
            step3();
            cyc++;
        end
        i_vld3 = 1'b0; o_rdy3 = 1'b0;
        chk("s3_rcv", 64'(rcv3), 64'd32);
        chk("s3_empty", 64'(empty3), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/gnrl_fifo.md
Name: gnrl_fifo

Overview:
- Synchronous, parameterised valid/ready FIFO.
- Built on the general flop library; used as the decoupling buffer between pipeline stages, e.g. the IFU-to-EXU instruction queue and the LSU response buffer.
- Storage and pointers are plain flops, not SRAM.
- One clock domain. First-word latency is one cycle.

Parameters:
- DW, 32, data width in bits.
- DP, 4, depth in entries. Legal range is 2..16 and need not be a power of two.
- CW, $clog2(DP+1), width of the occupancy count. Derived; must not be overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset.
- flush  input  1  synchronous clear of all queued entries.
- i_vld  input  1  upstream offers i_dat.
- i_rdy  output  1  FIFO can accept this cycle.
- i_dat  input  DW  write data.
- o_vld  output  1  o_dat holds the head entry.
- o_rdy  input  1  downstream consumes the head this cycle.
- o_dat  output  DW  head entry data.
- count  output  CW  number of valid entries.
- full  output  1  count == DP.
- empty  output  1  count == 0.

Interface decision: one clock; reset is asynchronous and active-high (rst asserted high clears state immediately, independent of clk).

Behaviour:
- Reset values:
  - wptr = 0, rptr = 0, count = 0.
  - empty = 1, full = 0, i_rdy = 1, o_vld = 0.
  - All storage entries = 0, so o_dat = 0.
- Handshakes:
  - Push when i_vld & i_rdy. Pop when o_vld & o_rdy. Both are sampled at the rising clk edge.
  - i_rdy = ~full; o_vld = ~empty. Both are pure functions of registered state, with no combinational path from i_vld or o_rdy.
- Push: mem[wptr] <= i_dat; wptr advances.
- Pop: rptr advances. o_dat = mem[rptr] is combinational from registered state.
- Pointer wrap: a pointer equal to DP-1 advances to 0 (explicit compare, not modulo-2^n). This is required for non-power-of-two DP.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together: count unchanged, and both pointers advance.
- Latency: data pushed at edge N is visible with o_vld = 1 after edge N. There is no same-cycle fall-through while empty.
- Full: i_rdy = 0, so i_vld is ignored and there is no state change. Push and pop cannot complete in the same cycle while full; the pop frees a slot for the next cycle.
- Empty: o_vld = 0, so o_rdy is ignored. Underflow is impossible.
- Ignored requests (i_vld without i_rdy, o_rdy without o_vld) must not modify pointers, count or storage.
- Flush:
  - Highest priority over push and pop in the same cycle.
  - Next state: wptr = rptr = 0, count = 0. Any push or pop in that cycle is discarded.
  - Storage contents are retained, not zeroed.
- Reset mid-operation: an asynchronous return to the reset values above, regardless of handshakes in flight.
- Invariants:
  - count == (wptr - rptr) mod DP, except when full, where the pointers are equal and count == DP.
  - full and empty are never both 1.

Test Plan:
- Reset/idle: assert rst mid-cycle with 2 entries queued -> immediately count = 0, o_vld = 0, i_rdy = 1, o_dat = 0. After release, push 0xA5A5_0001 -> o_vld = 1 and o_dat = 0xA5A5_0001 one cycle later.
- Fill/drain, DP = 4: push 0x1..0x5 back-to-back with o_rdy = 0 -> 0x1..0x4 accepted, full = 1, i_rdy = 0, 0x5 held off. Then o_rdy = 1 -> outputs 0x1, 0x2, 0x3, 0x4 in order, then 0x5 after re-acceptance, then empty = 1.
- Simultaneous push/pop at count = 2 for 10 cycles -> count stays 2, and data order matches the input order with exactly 2 cycles of queue delay.
- Wrap with non-power-of-two depth, DP = 3: stream 0x00..0x1F with random i_vld/o_rdy -> scoreboard matches, count never exceeds 3, pointers wrap 2 -> 0.
- Flush with i_vld = 1 and o_rdy = 1 at count = 3 -> next cycle count = 0, empty = 1, and the pushed word is lost. A subsequent push of 0xDEAD_BEEF appears as the first output.
- Ignored requests: o_rdy = 1 while empty and i_vld = 1 while full for 5 cycles -> count, pointers and o_dat unchanged.
